// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - configuration, fire handshake and status bundle for tick_scheduler
interface tick_scheduler_if #(
  parameter int PW = 16
);
  logic          clr;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [PW-1:0] cfg_period;
  logic          cfg_en;
  logic          fire_rdy;
  logic          ovr_clr;
  logic [3:0]    fire;
  logic [1:0]    fire_id;
  logic [3:0]    pending;
  logic [3:0]    overrun;

  modport master (
    output clr, cfg_we, cfg_ch, cfg_period, cfg_en, fire_rdy, ovr_clr,
    input  fire, fire_id, pending, overrun
  );

  modport slave (
    input  clr, cfg_we, cfg_ch, cfg_period, cfg_en, fire_rdy, ovr_clr,
    output fire, fire_id, pending, overrun
  );
endinterface

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - four-channel periodic tick scheduler with round-robin fire arbitration
module tick_scheduler #(
  parameter int CLKFREQ_MHZ = 100,
  parameter int BASE_US     = 1000,
  parameter int PW          = 16
) (
  input logic              clk,
  input logic              rst,
  tick_scheduler_if.slave  bus
);
  localparam int PRE_LIMIT = BASE_US * CLKFREQ_MHZ;
  localparam int PRE_W     = (PRE_LIMIT > 1) ? $clog2(PRE_LIMIT) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic             base_tick;
  logic [PW-1:0]    period [4];
  logic [PW-1:0]    cnt    [4];
  logic [3:0]       en;
  logic [3:0]       pending_q;
  logic [3:0]       overrun_q;
  logic [3:0]       fire_q;
  logic [1:0]       fire_id_q;
  logic [1:0]       rr_last;

  logic [3:0]       expire;
  logic [3:0]       cfg_hit;
  logic [3:0]       grant;
  logic [1:0]       grant_id;
  logic             grant_vld;

  assign base_tick = (pre_cnt == PRE_W'(PRE_LIMIT - 1));

  always_comb begin
    expire  = '0;
    cfg_hit = '0;
    for (int i = 0; i < 4; i++) begin
      expire[i]  = base_tick && en[i] && (period[i] != '0) && (cnt[i] == period[i] - PW'(1));
      cfg_hit[i] = bus.cfg_we && (bus.cfg_ch == 2'(i));
    end
  end

  // Search starts one past the last grant; offset 4 wraps back onto rr_last itself.
  always_comb begin
    logic [1:0] idx;
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    idx       = '0;
    if (bus.fire_rdy) begin
      for (int k = 1; k <= 4; k++) begin
        idx = rr_last + 2'(k);
        if (!grant_vld && pending_q[idx]) begin
          grant_vld  = 1'b1;
          grant_id   = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt   <= '0;
      en        <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      fire_q    <= '0;
      fire_id_q <= '0;
      rr_last   <= 2'd3;
      for (int i = 0; i < 4; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      pre_cnt <= (bus.clr || base_tick) ? '0 : pre_cnt + PRE_W'(1);

      for (int i = 0; i < 4; i++) begin
        if (cfg_hit[i]) begin
          period[i] <= bus.cfg_period;
          en[i]     <= bus.cfg_en;
        end

        // A config write or restart beats any expiry or grant landing in the same cycle.
        if (bus.clr || cfg_hit[i]) begin
          cnt[i]       <= '0;
          pending_q[i] <= 1'b0;
        end else begin
          if (base_tick && en[i] && (period[i] != '0))
            cnt[i] <= expire[i] ? '0 : cnt[i] + PW'(1);
          if (expire[i])
            pending_q[i] <= 1'b1;
          else if (grant[i])
            pending_q[i] <= 1'b0;
        end

        if (!bus.clr && !cfg_hit[i] && expire[i] && pending_q[i] && !grant[i])
          overrun_q[i] <= 1'b1;
        else if (bus.ovr_clr)
          overrun_q[i] <= 1'b0;
      end

      if (bus.clr) begin
        fire_q    <= '0;
        fire_id_q <= '0;
        rr_last   <= 2'd3;
      end else begin
        fire_q    <= grant;
        fire_id_q <= grant_id;
        if (grant_vld)
          rr_last <= grant_id;
      end
    end
  end

  assign bus.fire    = fire_q;
  assign bus.fire_id = fire_id_q;
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;
endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter CLKFREQ_MHZ, default 100, meaning the input clock frequency in MHz.
REQ-002 SHALL have parameter BASE_US, default 1000, meaning the base tick period in microseconds; prescaler limit PRE_LIMIT = BASE_US*CLKFREQ_MHZ clocks.
REQ-003 SHALL have parameter PW, default 16, meaning the per-channel period width in base ticks; channel count is fixed at 4.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port clr, input, 1, synchronous timebase restart that keeps the configuration.
REQ-007 SHALL have port cfg_we, input, 1, configuration write strobe.
REQ-008 SHALL have port cfg_ch, input, 2, channel index to write.
REQ-009 SHALL have port cfg_period, input, PW, period in base ticks.
REQ-010 SHALL have port cfg_en, input, 1, channel enable.
REQ-011 SHALL have port fire_rdy, input, 1, consumer able to accept a fire this cycle.
REQ-012 SHALL have port ovr_clr, input, 1, clears all overrun flags.
REQ-013 SHALL have port fire, output, 4, registered one-hot strobe for the serviced channel.
REQ-014 SHALL have port fire_id, output, 2, registered index of the fired channel; valid only while fire != 0.
REQ-015 SHALL have port pending, output, 4, per-channel expired-but-unserviced flags.
REQ-016 SHALL have port overrun, output, 4, sticky per-channel missed-service flags.

Function
REQ-017 Prescaler SHALL count 0..PRE_LIMIT-1 and assert internal base_tick for exactly one cycle when count == PRE_LIMIT-1, then wrap to 0.
REQ-018 Each channel SHALL hold period P, enable E and tick counter C; on base_tick with E=1 and P!=0: if C==P-1 then C<=0 and expire, else C<=C+1.
REQ-019 A channel with E=0 or P==0 SHALL hold C at 0 and never expire.
REQ-020 Expiry in cycle t SHALL set pending[ch] visible in cycle t+1.
REQ-021 An expiry while pending[ch] is already 1 and not being serviced that cycle SHALL set overrun[ch]; pending stays 1 (no queuing).
REQ-022 Arbiter SHALL, in any cycle with fire_rdy=1 and pending!=0, grant one channel round-robin, searching from the channel after the last granted (wrapping 3->0).
REQ-023 A grant in cycle t SHALL register fire one-hot and fire_id for cycle t+1 only, and clear pending[ch] at the same edge; best-case expiry-to-fire latency is 2 cycles.
REQ-024 Grant and new expiry of the same channel in the same cycle SHALL leave pending[ch]=1 and SHALL NOT set overrun.
REQ-025 fire_rdy=0 SHALL produce fire=0 the next cycle; pending flags are retained.
REQ-026 cfg_we SHALL load P and E of cfg_ch, and zero that channel's C and pending; overrun is unaffected; other channels are unaffected.
REQ-027 cfg_we to a channel in the same cycle as its expiry SHALL win: no pending set, no overrun.
REQ-028 ovr_clr SHALL zero overrun; an overrun event in the same cycle SHALL win (flag set).
REQ-029 clr SHALL zero prescaler, all C, pending, fire and fire_id and reset the round-robin pointer; P, E and overrun are retained; cfg_we in the same cycle is still applied.

Reset
REQ-030 rst SHALL zero prescaler, all P, E, C, pending, overrun, fire and fire_id, and set the round-robin pointer so channel 0 has top priority; rst overrides clr, cfg_we and ovr_clr.

Verification (CLKFREQ_MHZ=10, BASE_US=1, PRE_LIMIT=10)
REQ-031 rst, then write ch0 P=3 E=1, fire_rdy=1 -> fire=0001 one cycle, every 30 clocks, fire_id=0.
REQ-032 ch0 and ch1 both P=2 E=1, expiring on the same base_tick t -> fire=0001 in t+2, fire=0010 in t+3; next shared expiry ch1 first if pointer dictates, otherwise ch0 -> verify round-robin order alternates.
REQ-033 ch2 P=1 E=1, fire_rdy=0 for 25 clocks -> pending[2]=1, overrun[2]=1 after second expiry; fire_rdy=1 -> single fire=0100; ovr_clr -> overrun=0000.
REQ-034 cfg_we to ch0 (P=5) on the exact cycle ch0 would expire -> no pending, next fire 50 clocks later.
REQ-035 clr mid-count with ch1 P=4 -> pending=0000, first fire after a full 40 clocks; configuration retained.
REQ-036 rst asserted during a pending/fire cycle -> next cycle all outputs 0, no further fires until channels are reconfigured.
